vsync_timing_controller: RTL and testbench
==========================================

Name: vsync_timing_controller

Overview:
- Control and configuration front end for the video timing generator core.
- Holds a shadow copy of all timing parameters, written through a simple register write port.
- Transfers the shadow copy to the live parameter outputs only while the core is idle, so timing never changes mid-frame.
- Sequences start, stop and mode update by driving the core's enable and observing its busy flag.

Parameters:
- V_COUNTER_WIDTH, 12, width of the vertical timing parameters.
- H_COUNTER_WIDTH, 12, width of the horizontal timing parameters.
- DATA_WIDTH, 32, write data width; must be >= max(H_COUNTER_WIDTH, V_COUNTER_WIDTH, 2).
- INIT_HTOTAL / INIT_HDISP_START / INIT_HDISP_END / INIT_HSYNC_START / INIT_HSYNC_END, 1650/0/1280/1390/1430, reset values (720p60).
- INIT_VTOTAL / INIT_VDISP_START / INIT_VDISP_END / INIT_VSYNC_START / INIT_VSYNC_END, 750/0/720/725/730, reset values.
- INIT_HSYNC_POL / INIT_VSYNC_POL, 1/1, reset polarity (0 = negative, 1 = positive).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_wr_en  in  1  shadow register write strobe
- s_wr_addr  in  4  shadow register index
- s_wr_data  in  DATA_WIDTH  write data; LSBs are used
- ctl_start  in  1  pulse: apply shadow and run
- ctl_stop  in  1  pulse: stop at end of frame
- ctl_update  in  1  pulse: apply shadow at next frame boundary
- core_enable  out  1  drives the core's ctl_enable
- core_busy  in  1  from the core's ctl_busy
- param_htotal, param_hdisp_start, param_hdisp_end, param_hsync_start, param_hsync_end  out  H_COUNTER_WIDTH each  live horizontal parameters
- param_vtotal, param_vdisp_start, param_vdisp_end, param_vsync_start, param_vsync_end  out  V_COUNTER_WIDTH each  live vertical parameters
- param_hsync_pol, param_vsync_pol  out  1 each  live sync polarities
- st_running  out  1  high in RUN
- st_dirty  out  1  shadow differs from live (write since last apply)
- st_apply_done  out  1  one-cycle pulse in the cycle after the live parameters change

Behaviour:
- Reset: shadow and live registers take their INIT_* values. core_enable=0, st_running=0, st_dirty=0, st_apply_done=0. State is IDLE.
- Register map:
  - 0 htotal, 1 hdisp_start, 2 hdisp_end, 3 hsync_start, 4 hsync_end.
  - 5 vtotal, 6 vdisp_start, 7 vdisp_end, 8 vsync_start, 9 vsync_end.
  - 10 polarity: bit0 = hsync_pol, bit1 = vsync_pol.
  - Addresses 11-15 are ignored; a write to them does not set dirty.
- A write takes effect on the shadow copy the next cycle and sets st_dirty. The write is allowed in any state.
- States:
  - IDLE: core_enable=0. On ctl_start: go to WAIT_IDLE if core_busy=1, else go to APPLY.
  - WAIT_IDLE: core_enable=0. When core_busy=0, go to APPLY.
  - APPLY (one cycle): copy shadow to live, next cycle st_apply_done=1. Go to RUN if a run is pending (start or update path), else to IDLE.
  - RUN: core_enable=1, st_running=1.
    - ctl_stop: go to STOPPING.
    - ctl_update: go to DRAIN.
  - DRAIN: core_enable=0. When core_busy=0, go to APPLY, then RUN.
  - STOPPING: core_enable=0. When core_busy=0, go to IDLE. A pending update is discarded; the shadow stays dirty.
- The core samples enable only at frame end, so DRAIN and STOPPING last until the current frame completes. Live parameters never change while core_busy=1.
- Priority when pulses coincide: stop > update > start.
  - In RUN, stop and update together: stop wins.
  - In DRAIN, ctl_stop redirects to STOPPING.
  - In IDLE, stop and update are ignored.
  - In RUN and WAIT_IDLE, start is ignored.
- Write in the APPLY cycle: live receives the pre-write shadow value. The write lands in shadow and st_dirty stays 1. Otherwise APPLY clears st_dirty.
- Live parameter outputs are registered; they change exactly one cycle after the APPLY state.
- Reset mid-operation (any state) returns to the reset values immediately. The core is expected to be reset by the same signal.

Test Plan:
- Reset then ctl_start -> APPLY one cycle. Then core_enable=1, st_running=1, live params = 1650/0/1280/1390/1430/750/0/720/725/730, pol=1/1. st_apply_done pulses once.
- Running; write addr0=800 and addr5=525 -> st_dirty=1, param_htotal stays 1650. Then ctl_update with core_busy held high 100 cycles -> core_enable=0, params unchanged. core_busy falls -> param_htotal=800 and param_vtotal=525 one cycle after APPLY. core_enable re-asserts, st_dirty=0.
- Running; ctl_stop and ctl_update in the same cycle -> STOPPING. On core_busy=0 -> IDLE, params unchanged, st_dirty unchanged.
- Write addr10=0 in the APPLY cycle -> live pols stay 1/1, st_dirty=1. A following update applies pols 0/0.
- Writes to addr 11..15 -> no shadow change, st_dirty stays 0.
- Assert reset while in DRAIN with core_busy=1 -> next cycle state IDLE, core_enable=0, all params return to INIT values.

Source files
------------

// File: rtl/vsync_timing_controller.sv
// Configuration front end for the video timing core: shadow registers written through a
// simple port, transferred to the live outputs only while the core is idle.
module vsync_timing_controller #(
  parameter int V_COUNTER_WIDTH  = 12,
  parameter int H_COUNTER_WIDTH  = 12,
  parameter int DATA_WIDTH       = 32,
  parameter int INIT_HTOTAL      = 1650,
  parameter int INIT_HDISP_START = 0,
  parameter int INIT_HDISP_END   = 1280,
  parameter int INIT_HSYNC_START = 1390,
  parameter int INIT_HSYNC_END   = 1430,
  parameter int INIT_VTOTAL      = 750,
  parameter int INIT_VDISP_START = 0,
  parameter int INIT_VDISP_END   = 720,
  parameter int INIT_VSYNC_START = 725,
  parameter int INIT_VSYNC_END   = 730,
  parameter bit INIT_HSYNC_POL   = 1'b1,
  parameter bit INIT_VSYNC_POL   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_wr_en,
  input  logic [3:0]                 s_wr_addr,
  input  logic [DATA_WIDTH-1:0]      s_wr_data,
  input  logic                       ctl_start,
  input  logic                       ctl_stop,
  input  logic                       ctl_update,
  output logic                       core_enable,
  input  logic                       core_busy,
  output logic [H_COUNTER_WIDTH-1:0] param_htotal,
  output logic [H_COUNTER_WIDTH-1:0] param_hdisp_start,
  output logic [H_COUNTER_WIDTH-1:0] param_hdisp_end,
  output logic [H_COUNTER_WIDTH-1:0] param_hsync_start,
  output logic [H_COUNTER_WIDTH-1:0] param_hsync_end,
  output logic [V_COUNTER_WIDTH-1:0] param_vtotal,
  output logic [V_COUNTER_WIDTH-1:0] param_vdisp_start,
  output logic [V_COUNTER_WIDTH-1:0] param_vdisp_end,
  output logic [V_COUNTER_WIDTH-1:0] param_vsync_start,
  output logic [V_COUNTER_WIDTH-1:0] param_vsync_end,
  output logic                       param_hsync_pol,
  output logic                       param_vsync_pol,
  output logic                       st_running,
  output logic                       st_dirty,
  output logic                       st_apply_done
);

  localparam int HW = H_COUNTER_WIDTH;
  localparam int VW = V_COUNTER_WIDTH;

  localparam logic [HW-1:0] INIT_H [5] = '{HW'(INIT_HTOTAL), HW'(INIT_HDISP_START),
    HW'(INIT_HDISP_END), HW'(INIT_HSYNC_START), HW'(INIT_HSYNC_END)};
  localparam logic [VW-1:0] INIT_V [5] = '{VW'(INIT_VTOTAL), VW'(INIT_VDISP_START),
    VW'(INIT_VDISP_END), VW'(INIT_VSYNC_START), VW'(INIT_VSYNC_END)};

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_APPLY, S_RUN, S_DRAIN, S_STOPPING
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [HW-1:0] r_sh_h   [5];
  logic [HW-1:0] r_live_h [5];
  logic [VW-1:0] r_sh_v   [5];
  logic [VW-1:0] r_live_v [5];
  logic          r_sh_hpol, r_sh_vpol;
  logic          r_live_hpol, r_live_vpol;
  logic          r_dirty;
  logic          r_apply_done;

  logic w_wr_valid;
  logic w_apply;
  logic w_unused;

  assign w_wr_valid = s_wr_en && (s_wr_addr <= 4'd10);
  assign w_apply    = (r_state == S_APPLY);
  assign w_unused   = ^s_wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stop outranks update, which outranks start; each state only listens to the pulses it honours.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (ctl_start) w_state_next = core_busy ? S_WAIT_IDLE : S_APPLY;
      S_WAIT_IDLE: if (!core_busy) w_state_next = S_APPLY;
      S_APPLY:     w_state_next = S_RUN;
      S_RUN: begin
        if (ctl_stop)        w_state_next = S_STOPPING;
        else if (ctl_update) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (ctl_stop)        w_state_next = S_STOPPING;
        else if (!core_busy) w_state_next = S_APPLY;
      end
      S_STOPPING:  if (!core_busy) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Shadow takes writes in any state; live copies the pre-write shadow during APPLY.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        r_sh_h[i]   <= INIT_H[i];
        r_live_h[i] <= INIT_H[i];
        r_sh_v[i]   <= INIT_V[i];
        r_live_v[i] <= INIT_V[i];
      end
      r_sh_hpol    <= INIT_HSYNC_POL;
      r_sh_vpol    <= INIT_VSYNC_POL;
      r_live_hpol  <= INIT_HSYNC_POL;
      r_live_vpol  <= INIT_VSYNC_POL;
      r_dirty      <= 1'b0;
      r_apply_done <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (s_wr_en && s_wr_addr == 4'(i))     r_sh_h[i] <= s_wr_data[HW-1:0];
        if (s_wr_en && s_wr_addr == 4'(i + 5)) r_sh_v[i] <= s_wr_data[VW-1:0];
        if (w_apply) begin
          r_live_h[i] <= r_sh_h[i];
          r_live_v[i] <= r_sh_v[i];
        end
      end
      if (s_wr_en && s_wr_addr == 4'd10) begin
        r_sh_hpol <= s_wr_data[0];
        r_sh_vpol <= s_wr_data[1];
      end
      if (w_apply) begin
        r_live_hpol <= r_sh_hpol;
        r_live_vpol <= r_sh_vpol;
      end
      if (w_wr_valid)   r_dirty <= 1'b1;
      else if (w_apply) r_dirty <= 1'b0;
      r_apply_done <= w_apply;
    end
  end

  assign core_enable       = (r_state == S_RUN);
  assign st_running        = (r_state == S_RUN);
  assign st_dirty          = r_dirty;
  assign st_apply_done     = r_apply_done;
  assign param_htotal      = r_live_h[0];
  assign param_hdisp_start = r_live_h[1];
  assign param_hdisp_end   = r_live_h[2];
  assign param_hsync_start = r_live_h[3];
  assign param_hsync_end   = r_live_h[4];
  assign param_vtotal      = r_live_v[0];
  assign param_vdisp_start = r_live_v[1];
  assign param_vdisp_end   = r_live_v[2];
  assign param_vsync_start = r_live_v[3];
  assign param_vsync_end   = r_live_v[4];
  assign param_hsync_pol   = r_live_hpol;
  assign param_vsync_pol   = r_live_vpol;

endmodule

// File: tb/tb_vsync_timing_controller.sv
// Self-checking bench for vsync_timing_controller: per-cycle vector table with a
// scoreboard queue, plus hand sequences for reset-in-DRAIN and stop-in-DRAIN.
module tb_vsync_timing_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_wr_en;
  logic [3:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic        ctl_start, ctl_stop, ctl_update;
  logic        core_enable;
  logic        core_busy;
  logic [11:0] param_htotal, param_hdisp_start, param_hdisp_end, param_hsync_start, param_hsync_end;
  logic [11:0] param_vtotal, param_vdisp_start, param_vdisp_end, param_vsync_start, param_vsync_end;
  logic        param_hsync_pol, param_vsync_pol;
  logic        st_running, st_dirty, st_apply_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vsync_timing_controller dut (
    .clk(clk), .reset(reset),
    .s_wr_en(s_wr_en), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
    .ctl_start(ctl_start), .ctl_stop(ctl_stop), .ctl_update(ctl_update),
    .core_enable(core_enable), .core_busy(core_busy),
    .param_htotal(param_htotal), .param_hdisp_start(param_hdisp_start),
    .param_hdisp_end(param_hdisp_end), .param_hsync_start(param_hsync_start),
    .param_hsync_end(param_hsync_end),
    .param_vtotal(param_vtotal), .param_vdisp_start(param_vdisp_start),
    .param_vdisp_end(param_vdisp_end), .param_vsync_start(param_vsync_start),
    .param_vsync_end(param_vsync_end),
    .param_hsync_pol(param_hsync_pol), .param_vsync_pol(param_vsync_pol),
    .st_running(st_running), .st_dirty(st_dirty), .st_apply_done(st_apply_done)
  );

  typedef struct {
    logic        rst, wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        start, stop, upd, busy;
    logic        en, run, dirty, ad;
    logic [11:0] ht, vt;
    logic        hp, vp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t v(input logic rst, input logic wr, input logic [3:0] addr,
                             input logic [31:0] data, input logic start, input logic stop,
                             input logic upd, input logic busy, input logic en,
                             input logic run, input logic dirty, input logic ad,
                             input logic [11:0] ht, input logic [11:0] vt,
                             input logic hp, input logic vp);
    vec_t r;
    r.rst = rst; r.wr = wr; r.addr = addr; r.data = data;
    r.start = start; r.stop = stop; r.upd = upd; r.busy = busy;
    r.en = en; r.run = run; r.dirty = dirty; r.ad = ad;
    r.ht = ht; r.vt = vt; r.hp = hp; r.vp = vp;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, push the expectation, compare after the edge.
  task automatic step(input vec_t r, input int idx);
    vec_t e;
    @(negedge clk);
    reset = r.rst; s_wr_en = r.wr; s_wr_addr = r.addr; s_wr_data = r.data;
    ctl_start = r.start; ctl_stop = r.stop; ctl_update = r.upd; core_busy = r.busy;
    sb.push_back(r);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d core_enable", idx), int'(core_enable), int'(e.en));
    chk($sformatf("v%0d st_running", idx), int'(st_running), int'(e.run));
    chk($sformatf("v%0d st_dirty", idx), int'(st_dirty), int'(e.dirty));
    chk($sformatf("v%0d st_apply_done", idx), int'(st_apply_done), int'(e.ad));
    chk($sformatf("v%0d param_htotal", idx), int'(param_htotal), int'(e.ht));
    chk($sformatf("v%0d param_vtotal", idx), int'(param_vtotal), int'(e.vt));
    chk($sformatf("v%0d param_hsync_pol", idx), int'(param_hsync_pol), int'(e.hp));
    chk($sformatf("v%0d param_vsync_pol", idx), int'(param_vsync_pol), int'(e.vp));
    $display("step %0d: rst=%0b wr=%0b a=%0d d=%0d st/sp/up=%0b%0b%0b busy=%0b -> en=%0b dirty=%0b ad=%0b ht=%0d vt=%0d pol=%0b%0b",
             idx, r.rst, r.wr, r.addr, r.data, r.start, r.stop, r.upd, r.busy,
             core_enable, st_dirty, st_apply_done, param_htotal, param_vtotal,
             param_hsync_pol, param_vsync_pol);
  endtask

  task automatic chk_init_params(input string tag);
    chk({tag, " hdisp_start"}, int'(param_hdisp_start), 0);
    chk({tag, " hdisp_end"},   int'(param_hdisp_end),   1280);
    chk({tag, " hsync_start"}, int'(param_hsync_start), 1390);
    chk({tag, " hsync_end"},   int'(param_hsync_end),   1430);
    chk({tag, " vdisp_start"}, int'(param_vdisp_start), 0);
    chk({tag, " vdisp_end"},   int'(param_vdisp_end),   720);
    chk({tag, " vsync_start"}, int'(param_vsync_start), 725);
    chk({tag, " vsync_end"},   int'(param_vsync_end),   730);
  endtask

  initial begin
    int k;
    reset = 1'b1; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    ctl_start = 1'b0; ctl_stop = 1'b0; ctl_update = 1'b0; core_busy = 1'b0;

    // Reset, start, run, shadow writes, then update held off by a busy frame.
    tbl.push_back(v(1,0,0,0,   0,0,0,0, 0,0,0,0, 1650,750,1,1));
    tbl.push_back(v(1,0,0,0,   0,0,0,0, 0,0,0,0, 1650,750,1,1));
    tbl.push_back(v(0,0,0,0,   1,0,0,0, 0,0,0,0, 1650,750,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,0,1, 1,1,0,1, 1650,750,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,0,1, 1,1,0,0, 1650,750,1,1));
    tbl.push_back(v(0,1,0,800, 0,0,0,1, 1,1,1,0, 1650,750,1,1));
    tbl.push_back(v(0,1,5,525, 0,0,0,1, 1,1,1,0, 1650,750,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,1,1, 0,0,1,0, 1650,750,1,1));
    for (int i = 0; i < 100; i++)
      tbl.push_back(v(0,0,0,0, 0,0,0,1, 0,0,1,0, 1650,750,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,0,0, 0,0,1,0, 1650,750,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,0,1, 1,1,0,1, 800,525,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,0,1, 1,1,0,0, 800,525,1,1));
    // Stop and update together: stop wins, dirty survives.
    tbl.push_back(v(0,1,0,900, 0,0,0,1, 1,1,1,0, 800,525,1,1));
    tbl.push_back(v(0,0,0,0,   0,1,1,1, 0,0,1,0, 800,525,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,0,1, 0,0,1,0, 800,525,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,0,0, 0,0,1,0, 800,525,1,1));
    tbl.push_back(v(0,0,0,0,   0,1,1,0, 0,0,1,0, 800,525,1,1));
    // Polarity write during APPLY lands in shadow only.
    tbl.push_back(v(0,0,0,0,   1,0,0,0, 0,0,1,0, 800,525,1,1));
    tbl.push_back(v(0,1,10,0,  0,0,0,1, 1,1,1,1, 900,525,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,1,1, 0,0,1,0, 900,525,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,0,0, 0,0,1,0, 900,525,1,1));
    tbl.push_back(v(0,0,0,0,   0,0,0,1, 1,1,0,1, 900,525,0,0));
    // Unmapped addresses are ignored; start is ignored in RUN.
    for (int a = 11; a < 16; a++)
      tbl.push_back(v(0,1,4'(a),32'hFFFF_FFFF, 0,0,0,1, 1,1,0,0, 900,525,0,0));
    tbl.push_back(v(0,0,0,0,   1,0,0,1, 1,1,0,0, 900,525,0,0));

    k = 0;
    foreach (tbl[i]) begin
      step(tbl[i], k);
      if (k == 1) chk_init_params("reset");
      k++;
    end

    // Reset while in DRAIN with the core busy.
    step(v(0,1,0,100, 0,0,0,1, 1,1,1,0, 900,525,0,0), k++);
    step(v(0,0,0,0,   0,0,1,1, 0,0,1,0, 900,525,0,0), k++);
    step(v(1,0,0,0,   0,0,0,1, 0,0,0,0, 1650,750,1,1), k++);
    chk_init_params("drain reset");
    // Start with the core still busy goes through WAIT_IDLE; shadow was reset too.
    step(v(0,0,0,0,   1,0,0,1, 0,0,0,0, 1650,750,1,1), k++);
    step(v(0,0,0,0,   0,0,0,1, 0,0,0,0, 1650,750,1,1), k++);
    step(v(0,0,0,0,   0,0,0,0, 0,0,0,0, 1650,750,1,1), k++);
    step(v(0,0,0,0,   0,0,0,1, 1,1,0,1, 1650,750,1,1), k++);
    // Stop arriving in DRAIN redirects to STOPPING instead of applying.
    step(v(0,0,0,0,   0,0,1,1, 0,0,0,0, 1650,750,1,1), k++);
    step(v(0,0,0,0,   0,1,0,0, 0,0,0,0, 1650,750,1,1), k++);
    step(v(0,0,0,0,   0,0,0,0, 0,0,0,0, 1650,750,1,1), k++);
    step(v(0,0,0,0,   0,0,0,0, 0,0,0,0, 1650,750,1,1), k++);

    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
